// File: rtl/apb2axi_txn_mgr.sv
// Transaction manager between the tag directory and an AXI master port: issues
// popped descriptors as AR/AW, tracks R/B per tag and returns one completion per tag.

package apb2axi_pkg;
    localparam int TAG_NUM = 8;
    localparam int TAG_W   = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        is_write;
    } directory_entry_t;
endpackage

module apb2axi_txn_mgr
    import apb2axi_pkg::*;
#(
    parameter int TAG_NUM_P = TAG_NUM,
    parameter int TAG_W_P   = TAG_W,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 dir_pop_valid,
    input  directory_entry_t     dir_pop_entry,
    input  logic [TAG_W_P-1:0]   dir_pop_tag,
    output logic                 dir_pop_ready,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    output logic [ADDR_W-1:0]    m_araddr,
    output logic [TAG_W_P-1:0]   m_arid,
    output logic [7:0]           m_arlen,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [ADDR_W-1:0]    m_awaddr,
    output logic [TAG_W_P-1:0]   m_awid,
    output logic [7:0]           m_awlen,
    output logic [2:0]           m_awsize,
    output logic [1:0]           m_awburst,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    input  logic [TAG_W_P-1:0]   m_rid,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    input  logic                 m_bvalid,
    output logic                 m_bready,
    input  logic [TAG_W_P-1:0]   m_bid,
    input  logic [1:0]           m_bresp,
    output logic                 dir_cpl_valid,
    output logic [TAG_W_P-1:0]   dir_cpl_tag,
    output logic                 dir_cpl_is_write,
    output logic                 dir_cpl_error,
    output logic [1:0]           dir_cpl_resp,
    output logic [7:0]           dir_cpl_num_beats,
    input  logic                 dir_cpl_ready
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t             state_q, state_d;
    directory_entry_t   ent_q;
    logic [TAG_W_P-1:0] tag_q;
    logic               en_q;
    logic [OUT_W-1:0]   out_q;

    logic [7:0] len_q   [TAG_NUM_P];
    logic [7:0] beats_q [TAG_NUM_P];
    logic [1:0] resp_q  [TAG_NUM_P];

    logic       pop_hs, addr_hs, cpl_hs, slot_free;
    logic       r_hs, r_last_hs, b_hs;
    logic [7:0] beats_cur, beats_inc;
    logic [1:0] resp_new;
    logic       rd_err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        dir_pop_ready = 1'b0;
        m_arvalid     = 1'b0;
        m_awvalid     = 1'b0;
        case (state_q)
            IDLE: begin
                dir_pop_ready = en_q && (out_q < OUT_W'(MAX_OUT));
                if (dir_pop_ready && dir_pop_valid)
                    state_d = ADDR;
            end
            ADDR: begin
                m_arvalid = !ent_q.is_write;
                m_awvalid = ent_q.is_write;
                if (ent_q.is_write ? m_awready : m_arready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_hs  = dir_pop_valid && dir_pop_ready;
    assign addr_hs = (m_arvalid && m_arready) || (m_awvalid && m_awready);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ent_q <= '0;
            tag_q <= '0;
        end else if (pop_hs) begin
            ent_q <= dir_pop_entry;
            tag_q <= dir_pop_tag;
        end
    end

    // Both address channels share the latched descriptor; only the valids differ.
    assign m_araddr  = ADDR_W'(ent_q.addr);
    assign m_arid    = tag_q;
    assign m_arlen   = ent_q.len;
    assign m_arsize  = ent_q.size;
    assign m_arburst = {1'b0, m_arvalid};
    assign m_awaddr  = ADDR_W'(ent_q.addr);
    assign m_awid    = tag_q;
    assign m_awlen   = ent_q.len;
    assign m_awsize  = ent_q.size;
    assign m_awburst = {1'b0, m_awvalid};

    assign cpl_hs    = dir_cpl_valid && dir_cpl_ready;
    assign slot_free = !dir_cpl_valid || dir_cpl_ready;

    // Non-last beats never need the slot; a last beat yields to a pending B.
    assign m_bready  = en_q && slot_free;
    assign m_rready  = en_q && (!m_rlast || (slot_free && !m_bvalid));
    assign r_hs      = m_rvalid && m_rready;
    assign r_last_hs = r_hs && m_rlast;
    assign b_hs      = m_bvalid && m_bready;

    assign beats_cur = beats_q[m_rid];
    assign beats_inc = (beats_cur == 8'hFF) ? 8'hFF : beats_cur + 8'd1;
    assign resp_new  = (resp_q[m_rid] == 2'b00) ? m_rresp : resp_q[m_rid];
    assign rd_err    = resp_new[1] || (beats_cur != len_q[m_rid]);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_q <= '0;
        end else begin
            case ({addr_hs, cpl_hs})
                2'b10:   out_q <= out_q + OUT_W'(1);
                2'b01:   out_q <= out_q - OUT_W'(1);
                default: out_q <= out_q;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < TAG_NUM_P; i++) begin
                len_q[i]   <= '0;
                beats_q[i] <= '0;
                resp_q[i]  <= '0;
            end
        end else begin
            if (r_hs && !m_rlast) begin
                beats_q[m_rid] <= beats_inc;
                resp_q[m_rid]  <= resp_new;
            end
            if (addr_hs) begin
                len_q[tag_q]   <= ent_q.len;
                beats_q[tag_q] <= '0;
                resp_q[tag_q]  <= '0;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dir_cpl_valid     <= 1'b0;
            dir_cpl_tag       <= '0;
            dir_cpl_is_write  <= 1'b0;
            dir_cpl_error     <= 1'b0;
            dir_cpl_resp      <= '0;
            dir_cpl_num_beats <= '0;
        end else if (b_hs) begin
            dir_cpl_valid     <= 1'b1;
            dir_cpl_tag       <= m_bid;
            dir_cpl_is_write  <= 1'b1;
            dir_cpl_error     <= m_bresp[1];
            dir_cpl_resp      <= m_bresp;
            dir_cpl_num_beats <= len_q[m_bid] + 8'd1;
        end else if (r_last_hs) begin
            dir_cpl_valid     <= 1'b1;
            dir_cpl_tag       <= m_rid;
            dir_cpl_is_write  <= 1'b0;
            dir_cpl_error     <= rd_err;
            dir_cpl_resp      <= resp_new;
            dir_cpl_num_beats <= beats_inc;
        end else if (cpl_hs) begin
            dir_cpl_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb2axi_txn_mgr.sv
// Scoreboard bench for apb2axi_txn_mgr: directed test-plan cases plus randomized
// transactions, with expectations from a per-tag reference model.

module tb_apb2axi_txn_mgr;
    import apb2axi_pkg::*;

    localparam int MAXO = 2;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic             dir_pop_valid = 0;
    directory_entry_t dir_pop_entry = '0;
    logic [2:0]       dir_pop_tag = '0;
    logic             dir_pop_ready;
    logic             m_arvalid, m_arready = 0;
    logic [31:0]      m_araddr;
    logic [2:0]       m_arid;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;
    logic [1:0]       m_arburst;
    logic             m_awvalid, m_awready = 0;
    logic [31:0]      m_awaddr;
    logic [2:0]       m_awid;
    logic [7:0]       m_awlen;
    logic [2:0]       m_awsize;
    logic [1:0]       m_awburst;
    logic             m_rvalid = 0, m_rready;
    logic [2:0]       m_rid = '0;
    logic [1:0]       m_rresp = '0;
    logic             m_rlast = 0;
    logic             m_bvalid = 0, m_bready;
    logic [2:0]       m_bid = '0;
    logic [1:0]       m_bresp = '0;
    logic             dir_cpl_valid;
    logic [2:0]       dir_cpl_tag;
    logic             dir_cpl_is_write, dir_cpl_error;
    logic [1:0]       dir_cpl_resp;
    logic [7:0]       dir_cpl_num_beats;
    logic             dir_cpl_ready = 0;

    apb2axi_txn_mgr #(.TAG_NUM_P(8), .TAG_W_P(3), .ADDR_W(32), .MAX_OUT(MAXO)) dut (
        .pclk(pclk), .presetn(presetn),
        .dir_pop_valid(dir_pop_valid), .dir_pop_entry(dir_pop_entry),
        .dir_pop_tag(dir_pop_tag), .dir_pop_ready(dir_pop_ready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .dir_cpl_valid(dir_cpl_valid), .dir_cpl_tag(dir_cpl_tag),
        .dir_cpl_is_write(dir_cpl_is_write), .dir_cpl_error(dir_cpl_error),
        .dir_cpl_resp(dir_cpl_resp), .dir_cpl_num_beats(dir_cpl_num_beats),
        .dir_cpl_ready(dir_cpl_ready)
    );

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [2:0]  tag;
    } addr_exp_t;

    typedef struct {
        logic [2:0] tag;
        bit         is_write;
        bit         error;
        logic [1:0] resp;
        logic [7:0] num;
    } cpl_exp_t;

    addr_exp_t  aq[$];
    cpl_exp_t   cq[$];
    logic [7:0] exp_len[8];
    logic [1:0] rsq[$];
    int checks = 0;
    int errors = 0;
    int cpl_mode = 2;   // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge pclk);
        #2;
        m_arready = ($urandom_range(0, 2) != 0);
        m_awready = ($urandom_range(0, 2) != 0);
        case (cpl_mode)
            0:       dir_cpl_ready = ($urandom_range(0, 3) != 0);
            1:       dir_cpl_ready = 1'b0;
            default: dir_cpl_ready = 1'b1;
        endcase
    end

    // Monitor: pops expectations on every DUT handshake and checks hold-stability.
    initial begin
        logic        pa_v, pa_r, pc_v, pc_r, a_v, a_r;
        logic [48:0] pa_pl, a_pl;
        logic [14:0] pc_pl, c_pl;
        addr_exp_t   e;
        cpl_exp_t    c;
        pa_v = 0; pa_r = 0; pc_v = 0; pc_r = 0; pa_pl = '0; pc_pl = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                pa_v = 0; pc_v = 0;
            end else begin
                chk("ar_aw_exclusive", {31'd0, m_arvalid && m_awvalid}, 0);
                a_v  = m_arvalid || m_awvalid;
                a_r  = m_awvalid ? m_awready : m_arready;
                a_pl = m_awvalid ? {m_awvalid, m_awaddr, m_awlen, m_awsize, m_awid, m_awburst}
                                 : {m_awvalid, m_araddr, m_arlen, m_arsize, m_arid, m_arburst};
                c_pl = {dir_cpl_tag, dir_cpl_is_write, dir_cpl_error, dir_cpl_resp, dir_cpl_num_beats};
                if (pa_v && !pa_r)
                    chk("addr_stable", {31'd0, a_v && (a_pl == pa_pl)}, 1);
                if (pc_v && !pc_r)
                    chk("cpl_stable", {31'd0, dir_cpl_valid && (c_pl == pc_pl)}, 1);
                if (a_v && a_r) begin
                    if (aq.size() == 0) chk("addr_unexpected", 1, 0);
                    else begin
                        e = aq.pop_front();
                        chk("addr_is_write", {31'd0, m_awvalid}, {31'd0, e.is_write});
                        chk("addr_addr", m_awvalid ? m_awaddr : m_araddr, e.addr);
                        chk("addr_len", m_awvalid ? m_awlen : m_arlen, e.len);
                        chk("addr_size", m_awvalid ? m_awsize : m_arsize, e.size);
                        chk("addr_id", m_awvalid ? m_awid : m_arid, e.tag);
                        chk("addr_burst", m_awvalid ? m_awburst : m_arburst, 1);
                    end
                end
                if (dir_cpl_valid && dir_cpl_ready) begin
                    if (cq.size() == 0) chk("cpl_unexpected", 1, 0);
                    else begin
                        c = cq.pop_front();
                        chk("cpl_tag", dir_cpl_tag, c.tag);
                        chk("cpl_is_write", {31'd0, dir_cpl_is_write}, {31'd0, c.is_write});
                        chk("cpl_error", {31'd0, dir_cpl_error}, {31'd0, c.error});
                        chk("cpl_resp", dir_cpl_resp, c.resp);
                        chk("cpl_num_beats", dir_cpl_num_beats, c.num);
                    end
                end
                pa_v = a_v; pa_r = a_r; pa_pl = a_pl;
                pc_v = dir_cpl_valid; pc_r = dir_cpl_ready; pc_pl = c_pl;
            end
        end
    end

    task automatic do_pop(input int tag, input bit wr, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
        addr_exp_t e;
        bit hs = 0;
        dir_pop_valid = 1;
        dir_pop_entry = '{addr: addr, len: len, size: size, is_write: wr};
        dir_pop_tag   = 3'(tag);
        e = '{is_write: wr, addr: addr, len: len, size: size, tag: 3'(tag)};
        aq.push_back(e);
        exp_len[tag] = len;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge pclk); hs = dir_pop_ready;
            @(posedge pclk); #1;
        end
        dir_pop_valid = 0;
        if (!hs) chk("pop_timeout", 0, 1);
        else begin
            chk("issue_latency", {31'd0, m_arvalid || m_awvalid}, 1);
            chk("issue_channel", {31'd0, m_awvalid}, {31'd0, wr});
        end
    endtask

    task automatic send_r(input int tag, input logic [1:0] rs, input bit last);
        bit hs = 0;
        m_rvalid = 1; m_rid = 3'(tag); m_rresp = rs; m_rlast = last;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge pclk); hs = m_rready;
            @(posedge pclk); #1;
        end
        m_rvalid = 0; m_rlast = 0;
        if (!hs) chk("r_timeout", 0, 1);
    endtask

    task automatic send_b(input int tag, input logic [1:0] rs);
        bit hs = 0;
        m_bvalid = 1; m_bid = 3'(tag); m_bresp = rs;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge pclk); hs = m_bready;
            @(posedge pclk); #1;
        end
        m_bvalid = 0;
        if (!hs) chk("b_timeout", 0, 1);
    endtask

    // Reference: first non-OKAY beat wins; error on SLVERR/DECERR or beat count != len+1.
    task automatic push_read_exp(input int tag, input logic [1:0] rs[$]);
        cpl_exp_t c;
        logic [1:0] first = 2'b00;
        foreach (rs[i]) if (first == 2'b00) first = rs[i];
        c.tag = 3'(tag); c.is_write = 0; c.resp = first; c.num = 8'(rs.size());
        c.error = first[1] || (rs.size() != int'(exp_len[tag]) + 1);
        cq.push_back(c);
    endtask

    task automatic push_write_exp(input int tag, input logic [1:0] br);
        cpl_exp_t c;
        c.tag = 3'(tag); c.is_write = 1; c.resp = br; c.error = br[1];
        c.num = 8'(int'(exp_len[tag]) + 1);
        cq.push_back(c);
    endtask

    task automatic read_burst(input int tag, input logic [1:0] rs[$]);
        push_read_exp(tag, rs);
        foreach (rs[i]) send_r(tag, rs[i], i == rs.size() - 1);
    endtask

    task automatic wait_aq();
        for (int i = 0; i < 300 && aq.size() != 0; i++) begin @(posedge pclk); #1; end
        if (aq.size() != 0) begin chk("addr_drain_timeout", aq.size(), 0); aq.delete(); end
    endtask

    task automatic wait_cq();
        for (int i = 0; i < 300 && cq.size() != 0; i++) begin @(posedge pclk); #1; end
        if (cq.size() != 0) begin chk("cpl_drain_timeout", cq.size(), 0); cq.delete(); end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pop_ready"}, {31'd0, dir_pop_ready}, 0);
        chk({nm, "_arvalid"},   {31'd0, m_arvalid}, 0);
        chk({nm, "_awvalid"},   {31'd0, m_awvalid}, 0);
        chk({nm, "_rready"},    {31'd0, m_rready}, 0);
        chk({nm, "_bready"},    {31'd0, m_bready}, 0);
        chk({nm, "_cpl_valid"}, {31'd0, dir_cpl_valid}, 0);
    endtask

    initial begin
        int n, nb, k, kk;
        int tg[2];
        bit wr[2];
        logic [7:0] ln[2];
        logic [1:0] br;

        repeat (2) @(negedge pclk);
        chk_all_zero("reset");
        @(posedge pclk); #1; presetn = 1;

        // Read: tag 2, len 3, four OKAY beats.
        do_pop(2, 0, 32'h1000, 8'd3, 3'd2);
        wait_aq();
        rsq = {2'd0, 2'd0, 2'd0, 2'd0};
        read_burst(2, rsq);
        wait_cq();

        // Write error: tag 1, len 0, SLVERR.
        do_pop(1, 1, 32'h2000, 8'd0, 3'd3);
        wait_aq();
        push_write_exp(1, 2'd2);
        send_b(1, 2'd2);
        wait_cq();

        // Collision: RLAST tag 0 and B tag 1 together; B completes first.
        do_pop(0, 0, 32'h3000, 8'd0, 3'd2);
        do_pop(1, 1, 32'h4000, 8'd2, 3'd2);
        wait_aq();
        push_write_exp(1, 2'd0);
        rsq = {2'd0};
        push_read_exp(0, rsq);
        fork
            send_r(0, 2'd0, 1);
            send_b(1, 2'd0);
            begin @(negedge pclk); chk("collision_rready", {31'd0, m_rready}, 0); end
        join
        wait_cq();

        // Outstanding limit: two writes outstanding block a third pop until a completion.
        do_pop(3, 1, 32'h5000, 8'd1, 3'd2);
        do_pop(4, 1, 32'h6000, 8'd4, 3'd2);
        wait_aq();
        dir_pop_valid = 1;
        dir_pop_entry = '{addr: 32'h7000, len: 8'd1, size: 3'd2, is_write: 1'b0};
        dir_pop_tag = 3'd5;
        repeat (8) begin @(negedge pclk); chk("pop_ready_at_limit", {31'd0, dir_pop_ready}, 0); end
        @(posedge pclk); #1;
        push_write_exp(3, 2'd0);
        send_b(3, 2'd0);
        @(negedge pclk); chk("pop_ready_before_cpl", {31'd0, dir_pop_ready}, 0);
        @(posedge pclk); #1;
        do_pop(5, 0, 32'h7000, 8'd1, 3'd2);
        wait_aq();
        push_write_exp(4, 2'd1);
        send_b(4, 2'd1);
        rsq = {2'd0, 2'd0};
        read_burst(5, rsq);
        wait_cq();

        // Short burst, then mid-burst SLVERR.
        do_pop(6, 0, 32'h8000, 8'd3, 3'd2);
        wait_aq();
        rsq = {2'd0, 2'd0};
        read_burst(6, rsq);
        do_pop(7, 0, 32'h9000, 8'd3, 3'd2);
        wait_aq();
        rsq = {2'd0, 2'd2, 2'd0, 2'd0};
        read_burst(7, rsq);
        wait_cq();

        // Backpressure: slot held, B blocked, non-last R still flows.
        do_pop(2, 0, 32'hA000, 8'd1, 3'd2);
        do_pop(3, 1, 32'hB000, 8'd5, 3'd1);
        wait_aq();
        cpl_mode = 1;
        @(posedge pclk); #1;
        push_write_exp(3, 2'd1);
        send_b(3, 2'd1);
        repeat (5) begin
            @(negedge pclk);
            chk("bp_cpl_valid", {31'd0, dir_cpl_valid}, 1);
            chk("bp_bready", {31'd0, m_bready}, 0);
            chk("bp_rready_nonlast", {31'd0, m_rready}, 1);
        end
        @(posedge pclk); #1;
        send_r(2, 2'd0, 0);
        cpl_mode = 2;
        rsq = {2'd0, 2'd0};
        push_read_exp(2, rsq);
        send_r(2, 2'd0, 1);
        wait_cq();

        // Randomized transactions.
        cpl_mode = 0;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, MAXO);
            tg[0] = $urandom_range(0, 7);
            tg[1] = (tg[0] + $urandom_range(1, 7)) % 8;
            for (k = 0; k < n; k++) begin
                wr[k] = 1'($urandom_range(0, 1));
                ln[k] = 8'($urandom_range(0, 7));
                do_pop(tg[k], wr[k], $urandom & 32'hFFFF_FFFC, ln[k], 3'($urandom_range(0, 3)));
            end
            wait_aq();
            for (k = 0; k < n; k++) begin
                kk = (it % 2 == 1) ? n - 1 - k : k;
                if (wr[kk]) begin
                    br = 2'($urandom_range(0, 3));
                    push_write_exp(tg[kk], br);
                    send_b(tg[kk], br);
                end else begin
                    nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(ln[kk]) + 2)
                                                     : int'(ln[kk]) + 1;
                    rsq = {};
                    for (int b = 0; b < nb; b++)
                        rsq.push_back(($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
                    read_burst(tg[kk], rsq);
                end
            end
            wait_cq();
        end

        // Reset mid-burst: outputs drop asynchronously, no stale completion, counter cleared.
        cpl_mode = 2;
        do_pop(5, 0, 32'hC000, 8'd3, 3'd2);
        wait_aq();
        send_r(5, 2'd0, 0);
        send_r(5, 2'd2, 0);
        m_rlast = 1;
        #3 presetn = 0;
        #1 chk_all_zero("async_reset");
        m_rlast = 0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1;
        repeat (20) @(posedge pclk);
        #1;
        do_pop(0, 1, 32'hD000, 8'd2, 3'd2);
        do_pop(1, 1, 32'hE000, 8'd7, 3'd2);
        wait_aq();
        push_write_exp(0, 2'd0);
        send_b(0, 2'd0);
        push_write_exp(1, 2'd3);
        send_b(1, 2'd3);
        do_pop(5, 0, 32'hF000, 8'd1, 3'd2);
        wait_aq();
        rsq = {2'd0, 2'd0};
        read_burst(5, rsq);
        wait_cq();

        repeat (5) @(posedge pclk);
        chk("final_aq_empty", aq.size(), 0);
        chk("final_cq_empty", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb2axi_txn_mgr.md
Name: apb2axi_txn_mgr

Overview:
- Sits between the gateway tag directory and the AXI master port.
- Pops ALLOCATED descriptors from the directory and issues them as AXI AR or AW address transactions, using the tag as the AXI ID.
- Tracks R beats and B responses per tag.
- Returns exactly one completion per tag to the directory through the dir_cpl handshake.
- Write data and read data payloads are carried by separate blocks; this block owns address issue, response tracking and completion reporting only.

Parameters:
- TAG_NUM_P, TAG_NUM (pkg): number of tags; sizes the per-tag tracking arrays.
- TAG_W_P, TAG_W (pkg): tag/ID width.
- ADDR_W, 32: AXI address width.
- MAX_OUT, 4: maximum outstanding AXI transactions (reads plus writes); range 1..TAG_NUM_P.

Ports:
- pclk  in  1  clock
- presetn  in  1  async active-low reset
- dir_pop_valid  in  1  directory has an ALLOCATED entry
- dir_pop_entry  in  directory_entry_t  descriptor; uses fields addr, len, size, is_write
- dir_pop_tag  in  TAG_W_P  tag of the popped entry
- dir_pop_ready  out  1  accept pop
- m_arvalid/m_arready  out/in  1  AR handshake
- m_araddr  out  ADDR_W; m_arid  out  TAG_W_P; m_arlen  out  8; m_arsize  out  3; m_arburst  out  2
- m_awvalid/m_awready  out/in  1  AW handshake
- m_awaddr  out  ADDR_W; m_awid  out  TAG_W_P; m_awlen  out  8; m_awsize  out  3; m_awburst  out  2
- m_rvalid  in  1; m_rready  out  1; m_rid  in  TAG_W_P; m_rresp  in  2; m_rlast  in  1
- m_bvalid  in  1; m_bready  out  1; m_bid  in  TAG_W_P; m_bresp  in  2
- dir_cpl_valid  out  1; dir_cpl_tag  out  TAG_W_P; dir_cpl_is_write  out  1; dir_cpl_error  out  1; dir_cpl_resp  out  2; dir_cpl_num_beats  out  8
- dir_cpl_ready  in  1  directory accepts completion

Behaviour:
- Clock and reset:
  - One clock, pclk.
  - presetn is asynchronous, active-low. Assertion immediately clears all state, counters, valids and registered outputs to 0.
  - dir_pop_ready is 0 during reset.
  - Reset mid-burst abandons in-flight transactions; no completion is emitted for them.
- Issue FSM:
  - States: IDLE, ADDR.
  - IDLE: dir_pop_ready = (outstanding < MAX_OUT). On pop handshake, latch entry and tag, go to ADDR.
  - ADDR: drive m_arvalid if is_write=0, otherwise m_awvalid. Drive addr/len/size, id = tag, burst = 2'b01 (INCR). dir_pop_ready=0.
  - ADDR -> IDLE on the ar/aw handshake. At that point store len[tag] and is_write[tag], clear beats[tag], clear resp[tag], clear err[tag].
  - Latency: pop handshake at cycle N, valid asserted at N+1. Address outputs stay stable while valid=1 and ready=0.
  - Throughput: one issue per 2 cycles.
- Outstanding counter (0..MAX_OUT):
  - +1 on the ar/aw handshake; -1 on the dir_cpl handshake.
  - Both in the same cycle: no change.
- Completion slot:
  - Single register driving dir_cpl_*.
  - It is free when dir_cpl_valid=0 or a dir_cpl handshake occurs this cycle.
  - dir_cpl_valid and all payload fields stay stable until dir_cpl_ready.
- R channel:
  - Non-last beats: m_rready=1 always. On accept, beats[rid]++ (8-bit, saturates at 255). If rresp != 0 and resp[rid] == 0, set resp[rid] = rresp (first non-OKAY response wins).
  - Last beat (m_rlast=1): m_rready = slot_free && !m_bvalid. On accept, load the slot: tag=rid, is_write=0, num_beats = beats+1, resp = accumulated including this beat.
  - Read error: error = (final resp[1]==1) || (beats+1 != len[rid]+1). A beat-count mismatch sets error=1 but still reports the received resp.
- B channel:
  - m_bready = slot_free.
  - On accept, load the slot: tag=bid, is_write=1, num_beats = len[bid]+1, resp = bresp, error = bresp[1].
- Arbitration:
  - B and R-last both pending with the slot free: B wins. R is stalled (m_rready=0) until the next free slot.
- Backpressure:
  - dir_cpl_ready=0 with a slot held: m_bready=0 and last-beat m_rready=0.
  - Non-last R beats continue to be accepted.
- R or B for a tag not currently issued is a protocol violation; no check is performed.
- m_arvalid and m_awvalid are never both 1.

Test Plan:
- Read: pop tag=2 with is_write=0, len=3, size=2, addr=0x1000 -> m_arvalid at N+1 with arid=2, arlen=3, arburst=1. Then 4 R beats with OKAY -> dir_cpl tag=2, is_write=0, resp=0, error=0, num_beats=4.
- Write error: pop tag=1 with is_write=1, len=0 -> AW issued. B with bid=1, bresp=2 -> dir_cpl is_write=1, resp=2, error=1, num_beats=1.
- Collision: RLAST for tag 0 and B for tag 1 in the same cycle with the slot free -> cpl for tag 1 first, m_rready=0 that cycle. Tag 0 cpl follows after that handshake.
- Outstanding limit: MAX_OUT=2, three pops with no responses -> third dir_pop_ready stays 0 until the first dir_cpl handshake.
- Short burst: len=3 but m_rlast on the 2nd beat -> num_beats=2, error=1, resp=0. Mid-burst SLVERR followed by OKAY beats -> resp=2.
- Backpressure and reset: dir_cpl_ready held 0 for 5 cycles -> payload stable, m_bready=0. presetn asserted mid-burst -> all outputs 0 asynchronously, outstanding=0, no stale completion after release.
